// File: rtl/simon_sequencer.sv
// Simon game sequencer: replays an LFSR-derived colour sequence and checks the player's presses.
// Latency: one clock per fetch step; colours are lit SHOW_CYCLES and followed by GAP_CYCLES dark clocks.
// No backpressure; btn_pressed is only sampled in WAIT_BTN. SIMON_TIMEOUT_EN adds an input-wait timeout.
module simon_sequencer #(
    parameter int MAX_LEN        = 32,
    parameter int SHOW_CYCLES    = 50000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn_pressed,
    input  logic       random,
    output logic       lfsr_step,
    output logic       lfsr_rerun,
    output logic [1:0] color,
    output logic       led_enable,
    output logic [7:0] score,
    output logic       awaiting_input,
    output logic       game_over,
    output logic       game_won
);

    typedef enum logic [3:0] {
        S_IDLE, S_REWIND, S_FETCH_HI, S_FETCH_LO, S_SHOW, S_GAP, S_WAIT_BTN, S_LOSE, S_WIN
    } state_t;

    localparam logic [31:0] SHOW_LOAD = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TMO_LOAD  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  MAX_LEN8  = 8'(MAX_LEN);

    state_t      state, state_d;
    logic [1:0]  cur, cur_d;
    logic [1:0]  color_q, color_d;
    logic [7:0]  idx, idx_d;
    logic [7:0]  len, len_d;
    logic [7:0]  score_q, score_d;
    logic        phase_in, phase_in_d;    // 0 = replaying the sequence, 1 = collecting presses
    logic [31:0] timer, timer_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cur      <= '0;
            color_q  <= '0;
            idx      <= '0;
            len      <= '0;
            score_q  <= '0;
            phase_in <= 1'b0;
            timer    <= '0;
        end else begin
            state    <= state_d;
            cur      <= cur_d;
            color_q  <= color_d;
            idx      <= idx_d;
            len      <= len_d;
            score_q  <= score_d;
            phase_in <= phase_in_d;
            timer    <= timer_d;
        end
    end

    always_comb begin
        state_d    = state;
        cur_d      = cur;
        color_d    = color_q;
        idx_d      = idx;
        len_d      = len;
        score_d    = score_q;
        phase_in_d = phase_in;
        timer_d    = timer;
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    len_d      = 8'd1;
                    score_d    = 8'd0;
                    phase_in_d = 1'b0;
                    state_d    = S_REWIND;
                end
            end
            S_REWIND: begin
                idx_d   = 8'd0;
                state_d = S_FETCH_HI;
            end
            S_FETCH_HI: begin
                cur_d[1] = random;
                state_d  = S_FETCH_LO;
            end
            S_FETCH_LO: begin
                cur_d[0] = random;
                if (phase_in) begin
                    timer_d = TMO_LOAD;
                    state_d = S_WAIT_BTN;
                end else begin
                    color_d = {cur[1], random};
                    timer_d = SHOW_LOAD;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (timer == 32'd0) begin
                    idx_d   = idx + 8'd1;
                    timer_d = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer - 32'd1;
                end
            end
            S_GAP: begin
                if (timer != 32'd0) begin
                    timer_d = timer - 32'd1;
                end else if (idx != len) begin
                    state_d = S_FETCH_HI;
                end else if (!phase_in) begin
                    phase_in_d = 1'b1;
                    state_d    = S_REWIND;
                end else begin
                    score_d = len;
                    if (len == MAX_LEN8) begin
                        state_d = S_WIN;
                    end else begin
                        len_d      = len + 8'd1;
                        phase_in_d = 1'b0;
                        state_d    = S_REWIND;
                    end
                end
            end
            S_WAIT_BTN: begin
                // A press in the expiry cycle is decoded before the timeout.
                if (btn_pressed == (4'b0001 << cur)) begin
                    idx_d   = idx + 8'd1;
                    timer_d = GAP_LOAD;
                    state_d = S_GAP;
                end else if (btn_pressed != 4'b0000) begin
                    state_d = S_LOSE;
                end
`ifdef SIMON_TIMEOUT_EN
                else if (timer == 32'd0) begin
                    state_d = S_LOSE;
                end else begin
                    timer_d = timer - 32'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign lfsr_step      = (state == S_FETCH_HI) || (state == S_FETCH_LO);
    assign lfsr_rerun     = (state == S_REWIND);
    assign led_enable     = (state == S_SHOW);
    assign color          = color_q;
    assign score          = score_q;
    assign awaiting_input = (state == S_WAIT_BTN);
    assign game_over      = (state == S_LOSE);
    assign game_won       = (state == S_WIN);

endmodule
